paddle_motion_ctrl: RTL and testbench

- Downstream consumer of the PS/2 keyboard key-state decoder: takes per-player "key held" flags (P1 up/down, P2 up/down) and produces registered paddle Y positions for the Pong renderer and collision logic.
- Moves each paddle once per frame tick, with saturation at the playfield edges.
- Uses a per-paddle IDLE/SLOW/FAST state machine so a held key accelerates the paddle.

---
 rtl/pong_pkg.sv | 33 +++
 rtl/paddle_axis.sv | 140 ++++++++++++++
 rtl/paddle_motion_ctrl.sv | 93 +++++++++
 tb/tb_paddle_motion_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong types and playfield geometry: axis state / direction encodings, default
// screen and paddle sizes and the derived centre and bottom-most paddle positions.
package pong_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SLOW = 2'd1,
    S_FAST = 2'd2
  } axis_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_e;

  localparam int unsigned SCREEN_H_DEF = 120;
  localparam int unsigned PADDLE_H_DEF = 20;

  function automatic int unsigned calc_ymax(input int unsigned screen_h,
                                            input int unsigned paddle_h);
    return screen_h - paddle_h;
  endfunction

  function automatic int unsigned calc_center(input int unsigned screen_h,
                                              input int unsigned paddle_h);
    return (screen_h - paddle_h) / 2;
  endfunction

  localparam int unsigned YMAX_DEF   = calc_ymax(SCREEN_H_DEF, PADDLE_H_DEF);
  localparam int unsigned CENTER_DEF = calc_center(SCREEN_H_DEF, PADDLE_H_DEF);

endpackage

// File: rtl/paddle_axis.sv
// One paddle axis: key decode, IDLE/SLOW/FAST FSM, hold counter and saturating Y register.
// Acceleration (FAST state and hold counter) is built only when PADDLE_ACCEL_EN is defined.
module paddle_axis
  import pong_pkg::*;
#(
  parameter int unsigned Y_W         = 7,
  parameter int unsigned YMAX        = YMAX_DEF,
  parameter int unsigned CENTER      = CENTER_DEF,
  parameter int unsigned SLOW_STEP   = 1,
  parameter int unsigned FAST_STEP   = 3,
  parameter int unsigned ACCEL_TICKS = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           tick_i,
  input  logic           run_i,
  input  logic           recenter_i,
  input  logic           up_i,
  input  logic           down_i,
  output logic [Y_W-1:0] y_o,
  output logic           fast_o
);

  typedef logic [Y_W:0] yext_t;

  localparam yext_t          YMAX_X   = yext_t'(YMAX);
  localparam logic [Y_W-1:0] CENTER_Y = (Y_W)'(CENTER);

  axis_state_e    state_q, state_d;
  dir_e           dir_q, dir_d, dir;
  logic [Y_W-1:0] y_q, y_d;
  logic           move, use_fast;
  yext_t          y_ext, step, sum, y_new;

`ifdef PADDLE_ACCEL_EN
  localparam int unsigned     HW      = $clog2(ACCEL_TICKS + 1);
  localparam logic [HW-1:0]   ACCEL_H = HW'(ACCEL_TICKS);
  localparam logic [HW-1:0]   HOLD_1  = HW'(1);
  logic [HW-1:0] hold_q, hold_d;
`endif

  // Both keys held cancels out, same as no key.
  always_comb begin
    dir = NONE;
    if (up_i && !down_i)      dir = UP;
    else if (down_i && !up_i) dir = DOWN;
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    y_d      = y_q;
    move     = 1'b0;
    use_fast = 1'b0;
`ifdef PADDLE_ACCEL_EN
    hold_d   = hold_q;
`endif
    if (recenter_i) begin
      state_d = S_IDLE;
      dir_d   = NONE;
      y_d     = CENTER_Y;
`ifdef PADDLE_ACCEL_EN
      hold_d  = '0;
`endif
    end else if (tick_i) begin
      if (!run_i || dir == NONE) begin
        state_d = S_IDLE;
        dir_d   = NONE;
`ifdef PADDLE_ACCEL_EN
        hold_d  = '0;
`endif
      end else begin
        move  = 1'b1;
        dir_d = dir;
`ifdef PADDLE_ACCEL_EN
        unique case (state_q)
          S_SLOW: begin
            if (dir == dir_q) begin
              hold_d = hold_q + HOLD_1;
              if (hold_d >= ACCEL_H) state_d = S_FAST;
            end else begin
              hold_d = HOLD_1;
            end
          end
          S_FAST: begin
            if (dir == dir_q) begin
              use_fast = 1'b1;
            end else begin
              state_d = S_SLOW;
              hold_d  = HOLD_1;
            end
          end
          default: begin
            state_d = S_SLOW;
            hold_d  = HOLD_1;
          end
        endcase
`else
        state_d = S_SLOW;
`endif
      end
    end
  end

  // Saturating move, one bit wider than Y so the down-sum cannot wrap.
  always_comb begin
    y_ext = {1'b0, y_q};
    step  = use_fast ? yext_t'(FAST_STEP) : yext_t'(SLOW_STEP);
    sum   = y_ext + step;
    y_new = y_ext;
    if (dir_d == UP) y_new = (y_ext < step) ? '0 : y_ext - step;
    else             y_new = (sum > YMAX_X) ? YMAX_X : sum;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      dir_q   <= NONE;
      y_q     <= CENTER_Y;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      y_q     <= (move && !recenter_i) ? y_new[Y_W-1:0] : y_d;
    end
  end

`ifdef PADDLE_ACCEL_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) hold_q <= '0;
    else       hold_q <= hold_d;
  end

  assign fast_o = (state_q == S_FAST);
`else
  assign fast_o = 1'b0;
`endif

  assign y_o = y_q;

endmodule

// File: rtl/paddle_motion_ctrl.sv
// Pong paddle motion: frame-tick generator plus two independent paddle axes.
// Define PADDLE_ACCEL_EN to enable the SLOW->FAST acceleration of held keys.
module paddle_motion_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SCREEN_H    = SCREEN_H_DEF,
  parameter int unsigned PADDLE_H    = PADDLE_H_DEF,
  parameter int unsigned Y_W         = 7,
  parameter int unsigned TICK_DIV    = 833333,
  parameter int unsigned SLOW_STEP   = 1,
  parameter int unsigned FAST_STEP   = 3,
  parameter int unsigned ACCEL_TICKS = 8
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           p1_up,
  input  logic           p1_down,
  input  logic           p2_up,
  input  logic           p2_down,
  input  logic           run,
  input  logic           recenter,
  output logic [Y_W-1:0] p1_y,
  output logic [Y_W-1:0] p2_y,
  output logic           frame_tick,
  output logic           p1_fast,
  output logic           p2_fast
);

  localparam int unsigned       CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(TICK_DIV - 1);
  localparam int unsigned       YMAX    = calc_ymax(SCREEN_H, PADDLE_H);
  localparam int unsigned       CENTER  = calc_center(SCREEN_H, PADDLE_H);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Free-running divider; recenter and run deliberately do not touch it.
  always_comb begin
    tick_d = (cnt_q == CNT_TOP);
    cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign frame_tick = tick_q;

  paddle_axis #(
    .Y_W         (Y_W),
    .YMAX        (YMAX),
    .CENTER      (CENTER),
    .SLOW_STEP   (SLOW_STEP),
    .FAST_STEP   (FAST_STEP),
    .ACCEL_TICKS (ACCEL_TICKS)
  ) u_p1_axis (
    .clk_i      (CLOCK_50),
    .rst_i      (reset),
    .tick_i     (tick_q),
    .run_i      (run),
    .recenter_i (recenter),
    .up_i       (p1_up),
    .down_i     (p1_down),
    .y_o        (p1_y),
    .fast_o     (p1_fast)
  );

  paddle_axis #(
    .Y_W         (Y_W),
    .YMAX        (YMAX),
    .CENTER      (CENTER),
    .SLOW_STEP   (SLOW_STEP),
    .FAST_STEP   (FAST_STEP),
    .ACCEL_TICKS (ACCEL_TICKS)
  ) u_p2_axis (
    .clk_i      (CLOCK_50),
    .rst_i      (reset),
    .tick_i     (tick_q),
    .run_i      (run),
    .recenter_i (recenter),
    .up_i       (p2_up),
    .down_i     (p2_down),
    .y_o        (p2_y),
    .fast_o     (p2_fast)
  );

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Self-checking bench for paddle_motion_ctrl (TICK_DIV = 4) against a run-length model of
// paddle motion; follows PADDLE_ACCEL_EN to decide whether acceleration is expected.
module tb_paddle_motion_ctrl;

  localparam int TICK   = 4;
  localparam int YMAX   = 100;
  localparam int CENTER = 50;
  localparam int SLOW   = 1;
  localparam int FASTS  = 3;
  localparam int ACCEL  = 8;
`ifdef PADDLE_ACCEL_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic       run = 1'b0, recenter = 1'b0;
  logic [6:0] p1_y, p2_y;
  logic       frame_tick, p1_fast, p2_fast;

  paddle_motion_ctrl #(
    .TICK_DIV (TICK)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .p1_up      (p1_up),
    .p1_down    (p1_down),
    .p2_up      (p2_up),
    .p2_down    (p2_down),
    .run        (run),
    .recenter   (recenter),
    .p1_y       (p1_y),
    .p2_y       (p2_y),
    .frame_tick (frame_tick),
    .p1_fast    (p1_fast),
    .p2_fast    (p2_fast)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: position, count of consecutive same-direction moving ticks, last direction (-1/0/+1).
  int my[2];
  int streak[2];
  int ldir[2];
  int n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > YMAX) return YMAX;
    return v;
  endfunction

  function automatic bit tick_now();
    return (n > 0) && (n % TICK == 0);
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 2; a++) begin
      my[a]     = CENTER;
      streak[a] = 0;
      ldir[a]   = 0;
    end
    n = 0;
  endtask

  task automatic model_edge();
    int d;
    bit fast;
    bit u[2];
    bit dn[2];
    u[0] = p1_up; dn[0] = p1_down; u[1] = p2_up; dn[1] = p2_down;
    if (recenter) begin
      for (int a = 0; a < 2; a++) begin
        my[a] = CENTER; streak[a] = 0; ldir[a] = 0;
      end
    end else if (tick_now()) begin
      for (int a = 0; a < 2; a++) begin
        d = (u[a] && !dn[a]) ? -1 : (dn[a] && !u[a]) ? 1 : 0;
        if (!run || d == 0) begin
          streak[a] = 0; ldir[a] = 0;
        end else begin
          fast      = ACC && (d == ldir[a]) && (streak[a] >= ACCEL);
          streak[a] = (d == ldir[a] && streak[a] > 0) ? streak[a] + 1 : 1;
          ldir[a]   = d;
          my[a]     = clamp(my[a] + d * (fast ? FASTS : SLOW));
        end
      end
    end
    n++;
  endtask

  task automatic check_all(input string where);
    check($sformatf("%s p1_y", where), 32'(p1_y), my[0]);
    check($sformatf("%s p2_y", where), 32'(p2_y), my[1]);
    check($sformatf("%s frame_tick", where), 32'(frame_tick), 32'(tick_now()));
    check($sformatf("%s p1_fast", where), 32'(p1_fast), 32'(ACC && streak[0] >= ACCEL));
    check($sformatf("%s p2_fast", where), 32'(p2_fast), 32'(ACC && streak[1] >= ACCEL));
  endtask

  task automatic cycle(input string where);
    @(posedge clk);
    model_edge();
    #1;
    check_all(where);
  endtask

  task automatic run_ticks(input string where, input int k);
    for (int i = 0; i < k * TICK; i++) cycle(where);
  endtask

  initial begin
    // Reset and release
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;
    run   = 1'b1;
    run_ticks("idle", 3);

    // Single-direction holds on each paddle
    p1_up = 1'b1;
    run_ticks("p1_up5", 5);
    p1_up   = 1'b0;
    p2_down = 1'b1;
    run_ticks("p2_down12", 12);
    p2_down = 1'b0;
    run_ticks("release", 1);

    // Drive p1 into both edges
    p1_up = 1'b1;
    run_ticks("p1_clamp_top", 60);
    p1_up   = 1'b0;
    p1_down = 1'b1;
    run_ticks("p1_clamp_bot", 110);

    // Both keys on one axis cancel, then releasing one resumes motion
    p1_up = 1'b1;
    run_ticks("p1_both", 3);
    p1_down = 1'b0;
    run_ticks("p1_up_resume", 3);

    // Reversal while moving
    p1_up   = 1'b0;
    p1_down = 1'b1;
    run_ticks("p1_reverse", 3);

    // Freeze with keys held
    run = 1'b0;
    run_ticks("frozen", 4);
    run = 1'b1;
    run_ticks("unfrozen", 2);

    // Recenter coinciding with a frame tick while both axes are moving
    p2_up = 1'b1;
    run_ticks("pre_recenter", 10);
    while (!tick_now()) cycle("align");
    recenter = 1'b1;
    cycle("recenter_tick");
    recenter = 1'b0;
    run_ticks("post_recenter", 3);

    // Randomized traffic
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 47) == 0) begin
        {p1_up, p1_down, p2_up, p2_down} = 4'($urandom_range(0, 15));
      end
      run      = ($urandom_range(0, 15) != 0);
      recenter = ($urandom_range(0, 63) == 0);
      cycle("random");
    end
    recenter = 1'b0;
    run      = 1'b1;

    // Asynchronous reset in the middle of a move
    p1_up = 1'b0; p1_down = 1'b1; p2_up = 1'b1; p2_down = 1'b0;
    run_ticks("pre_reset", 4);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_ticks("after_reset", 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
